// File: rtl/clk_div_n.sv
// clk_div_n: programmable integer clock divider, divisor 2..2^WIDTH-1.
// Counter cnt runs 0..N-1 on clk_in posedge; pos_hi is high for the first
// floor(N/2) counts of each period and drives clk_out for even N.
// Optional feature macro CLK_DIV_ODD_DUTY_EN: adds one negedge flop so that
// odd divisors also produce an exact 50% duty cycle. Without it, odd N gives
// high floor(N/2) cycles, low ceil(N/2) cycles.
//
// Divisor load protocol: div_load is a single-cycle request qualified only by
// div_in. A value >= 2 is accepted into the pending register (div_pend rises
// next cycle, a later accepted load overwrites it); a value < 2 is rejected
// with a one-cycle div_err pulse and leaves the pending state untouched.
// A pending value is adopted only at a period boundary while running, so
// there is never a truncated or stretched period.
module clk_div_n #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] cur_div,
  output logic             div_pend,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_CNT = WIDTH'(DEFAULT_DIV - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pos_hi_q, pos_hi_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_val_q, pend_val_d;
  logic             div_pend_q, div_pend_d;
  logic             div_err_q, div_err_d;

  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] last_cnt;
  logic [WIDTH-1:0] half_div;
  logic             boundary;
  logic             load_ok;
  logic             load_bad;

  assign cnt_inc  = cnt_q + WIDTH'(1);
  assign last_cnt = cur_div_q - WIDTH'(1);
  assign half_div = cur_div_q >> 1;
  assign boundary = (cnt_q == last_cnt);
  assign load_ok  = div_load && (div_in > WIDTH'(1));
  assign load_bad = div_load && (div_in <= WIDTH'(1));

  // Next-state: period counter, high-phase flag, boundary handling, divisor load.
  always_comb begin
    cnt_d      = cnt_q;
    pos_hi_d   = pos_hi_q;
    tick_d     = 1'b0;
    cur_div_d  = cur_div_q;
    pend_val_d = pend_val_q;
    div_pend_d = div_pend_q;
    div_err_d  = load_bad;

    if (boundary) begin
      if (en) begin
        // New period starts; cnt = 0 is always inside the high phase (N >= 2).
        cnt_d    = '0;
        pos_hi_d = 1'b1;
        tick_d   = 1'b1;
        if (div_pend_q) begin
          cur_div_d  = pend_val_q;
          div_pend_d = 1'b0;
        end
      end else begin
        // Stopped: park at the last count so every posedge stays a boundary.
        cnt_d    = cnt_q;
        pos_hi_d = 1'b0;
      end
    end else begin
      cnt_d    = cnt_inc;
      pos_hi_d = (cnt_inc < half_div);
    end

    // A load sampled on a boundary becomes pending for the following boundary,
    // because the adoption above used the value that was already pending.
    if (load_ok) begin
      pend_val_d = div_in;
      div_pend_d = 1'b1;
    end
  end

  // Posedge state registers; reset is a valid stopped state.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt_q      <= DEF_CNT;
      pos_hi_q   <= 1'b0;
      tick_q     <= 1'b0;
      cur_div_q  <= DEF_DIV;
      pend_val_q <= DEF_DIV;
      div_pend_q <= 1'b0;
      div_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pos_hi_q   <= pos_hi_d;
      tick_q     <= tick_d;
      cur_div_q  <= cur_div_d;
      pend_val_q <= pend_val_d;
      div_pend_q <= div_pend_d;
      div_err_q  <= div_err_d;
    end
  end

`ifdef CLK_DIV_ODD_DUTY_EN
  logic neg_q, neg_d;

  assign neg_d = pos_hi_q;

  // Negedge copy of pos_hi extends the odd-N high phase by half a cycle.
  always_ff @(negedge clk_in or negedge reset) begin
    if (!reset) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end

  // At every divisor switch pos_hi and neg_q are both low, so the mux is clean.
  assign clk_out = cur_div_q[0] ? (pos_hi_q | neg_q) : pos_hi_q;
`else
  assign clk_out = pos_hi_q;
`endif

  assign tick     = tick_q;
  assign cur_div  = cur_div_q;
  assign div_pend = div_pend_q;
  assign div_err  = div_err_q;

endmodule

// File: tb/tb_clk_div_n.sv
// tb_clk_div_n: self-checking bench for clk_div_n (WIDTH = 8, DEFAULT_DIV = 3).
// Expected per-cycle observations are pushed with the stimulus and popped as
// the DUT produces them. Each entry holds the values seen #1 after a posedge
// (div_err, tick, clk_out, div_pend, cur_div) and clk_out #1 after the
// following negedge.
module tb_clk_div_n;

  logic       clk_in;
  logic       reset;
  logic       en;
  logic [7:0] div_in;
  logic       div_load;
  logic       clk_out;
  logic       tick;
  logic [7:0] cur_div;
  logic       div_pend;
  logic       div_err;

  // entry layout: [12] err [11] tick [10] clk@pos [9] clk@neg [8] pend [7:0] cur_div
  logic [12:0] exp_q[$];
  // stimulus layout: [9] en [8] div_load [7:0] div_in
  logic [9:0]  stim_q[$];

  int n_checks;
  int n_fail;

  clk_div_n #(.WIDTH(8), .DEFAULT_DIV(3)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .clk_out  (clk_out),
    .tick     (tick),
    .cur_div  (cur_div),
    .div_pend (div_pend),
    .div_err  (div_err)
  );

  // ---------------- clock / reset ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  // clk_out level for half-cycle index 'half' (0 = just after the period's
  // first posedge). With odd-duty the high phase is N half-cycles for any N;
  // otherwise it is floor(N/2) whole cycles.
  function automatic logic lvl(input int n, input int half);
    int hi;
`ifdef CLK_DIV_ODD_DUTY_EN
    hi = n;
`else
    hi = 2 * (n / 2);
`endif
    return (half < hi);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_cyc(input logic en_v, input logic ld, input logic [7:0] din,
                          input logic err, input logic tk, input logic po,
                          input logic ne, input logic pend, input logic [7:0] cur);
    stim_q.push_back({en_v, ld, din});
    exp_q.push_back({err, tk, po, ne, pend, cur});
  endtask

  // One running period of divisor n with no loads.
  task automatic push_period(input int n, input logic pend);
    for (int c = 0; c < n; c++)
      push_cyc(1'b1, 1'b0, 8'd0, 1'b0, (c == 0), lvl(n, 2 * c), lvl(n, 2 * c + 1),
               pend, 8'(n));
  endtask

  task automatic step_obs(output logic [12:0] obs);
    @(posedge clk_in);
    #1;
    obs = {div_err, tick, clk_out, 1'b0, div_pend, cur_div};
    @(negedge clk_in);
    #1;
    obs[9] = clk_out;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset    = 1'b0;
    en       = 1'b1;
    div_load = 1'b0;
    div_in   = 8'd0;
    repeat (2) @(posedge clk_in);
    #1;
    n_checks++;
    if (clk_out !== 1'b0) begin n_fail++; $display("FAIL reset_clk_out: got %b expected 0", clk_out); end
    n_checks++;
    if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", tick); end
    n_checks++;
    if (cur_div !== 8'd3) begin n_fail++; $display("FAIL reset_cur_div: got %0d expected 3", cur_div); end
    n_checks++;
    if (div_pend !== 1'b0) begin n_fail++; $display("FAIL reset_div_pend: got %b expected 0", div_pend); end
    n_checks++;
    if (div_err !== 1'b0) begin n_fail++; $display("FAIL reset_div_err: got %b expected 0", div_err); end
    @(negedge clk_in);
    #1;
    reset = 1'b1;
  endtask

  // Default divisor 3 straight out of reset; first posedge must rise with tick.
  task automatic test_default_div;
    logic [9:0] s; logic [12:0] obs, e; int idx;
    repeat (4) push_period(3, 1'b0);
    idx = 0;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      {en, div_load, div_in} = s;
      step_obs(obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL default_div cyc %0d: got %h expected %h", idx, obs, e);
      end
      idx++;
    end
  endtask

  // Load sampled on the boundary itself: that boundary keeps N=3, next uses 5.
  task automatic test_boundary_load;
    logic [9:0] s; logic [12:0] obs, e; int idx;
    for (int c = 0; c < 3; c++)
      push_cyc(1'b1, (c == 0), 8'd5, 1'b0, (c == 0), lvl(3, 2 * c), lvl(3, 2 * c + 1),
               1'b1, 8'd3);
    push_period(5, 1'b0);
    idx = 0;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      {en, div_load, div_in} = s;
      step_obs(obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL boundary_load cyc %0d: got %h expected %h", idx, obs, e);
      end
      idx++;
    end
  endtask

  // Load 8 during cnt=0 under N=5: pending for 4 cycles, then clean 4/4 periods.
  task automatic test_div_change;
    logic [9:0] s; logic [12:0] obs, e; int idx;
    for (int c = 0; c < 5; c++)
      push_cyc(1'b1, (c == 1), 8'd8, 1'b0, (c == 0), lvl(5, 2 * c), lvl(5, 2 * c + 1),
               (c >= 1), 8'd5);
    repeat (2) push_period(8, 1'b0);
    idx = 0;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      {en, div_load, div_in} = s;
      step_obs(obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL div_change cyc %0d: got %h expected %h", idx, obs, e);
      end
      idx++;
    end
  endtask

  // Rejected loads (1 and 0), overwrite of a pending value, and a rejected
  // load while pending that must not disturb the pending value.
  task automatic test_bad_load;
    logic [9:0] s; logic [12:0] obs, e; int idx;
    logic ld; logic [7:0] din;
    for (int c = 0; c < 8; c++) begin
      ld  = (c == 1) || (c == 3);
      din = (c == 1) ? 8'd1 : 8'd0;
      push_cyc(1'b1, ld, din, ld, (c == 0), lvl(8, 2 * c), lvl(8, 2 * c + 1), 1'b0, 8'd8);
    end
    for (int c = 0; c < 8; c++) begin
      ld  = (c == 1) || (c == 3) || (c == 5);
      din = (c == 1) ? 8'd6 : (c == 3) ? 8'd4 : 8'd1;
      push_cyc(1'b1, ld, din, (c == 5), (c == 0), lvl(8, 2 * c), lvl(8, 2 * c + 1),
               (c >= 1), 8'd8);
    end
    repeat (2) push_period(4, 1'b0);
    idx = 0;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      {en, div_load, div_in} = s;
      step_obs(obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL bad_load cyc %0d: got %h expected %h", idx, obs, e);
      end
      idx++;
    end
  endtask

  // Switch to N=6, reload the same value, then drop en mid-period and restart.
  task automatic test_en_stop;
    logic [9:0] s; logic [12:0] obs, e; int idx;
    for (int c = 0; c < 4; c++)
      push_cyc(1'b1, (c == 1), 8'd6, 1'b0, (c == 0), lvl(4, 2 * c), lvl(4, 2 * c + 1),
               (c >= 1), 8'd4);
    for (int c = 0; c < 6; c++)
      push_cyc(1'b1, (c == 2), 8'd6, 1'b0, (c == 0), lvl(6, 2 * c), lvl(6, 2 * c + 1),
               (c >= 2), 8'd6);
    for (int c = 0; c < 6; c++)
      push_cyc((c < 3), 1'b0, 8'd0, 1'b0, (c == 0), lvl(6, 2 * c), lvl(6, 2 * c + 1),
               1'b0, 8'd6);
    repeat (5) push_cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd6);
    repeat (2) push_period(6, 1'b0);
    idx = 0;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      {en, div_load, div_in} = s;
      step_obs(obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL en_stop cyc %0d: got %h expected %h", idx, obs, e);
      end
      idx++;
    end
  endtask

  // Reset during the high phase with a load pending: output drops at once,
  // the pending load is discarded and the default divisor resumes.
  task automatic test_reset_mid;
    logic [9:0] s; logic [12:0] obs, e; int idx;
    for (int c = 0; c < 3; c++)
      push_cyc(1'b1, (c == 1), 8'd9, 1'b0, (c == 0), lvl(6, 2 * c), lvl(6, 2 * c + 1),
               (c >= 1), 8'd6);
    idx = 0;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      {en, div_load, div_in} = s;
      step_obs(obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid_pre cyc %0d: got %h expected %h", idx, obs, e);
      end
      idx++;
    end
    div_load = 1'b0;
    en       = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (clk_out !== 1'b0) begin n_fail++; $display("FAIL reset_mid_clk_out: got %b expected 0", clk_out); end
    n_checks++;
    if (cur_div !== 8'd3) begin n_fail++; $display("FAIL reset_mid_cur_div: got %0d expected 3", cur_div); end
    n_checks++;
    if (div_pend !== 1'b0) begin n_fail++; $display("FAIL reset_mid_div_pend: got %b expected 0", div_pend); end
    @(posedge clk_in);
    @(negedge clk_in);
    #1;
    n_checks++;
    if (clk_out !== 1'b0) begin n_fail++; $display("FAIL reset_mid_hold: got %b expected 0", clk_out); end
    reset = 1'b1;
    repeat (2) push_period(3, 1'b0);
    idx = 0;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      {en, div_load, div_in} = s;
      step_obs(obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid_post cyc %0d: got %h expected %h", idx, obs, e);
      end
      idx++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_default_div();
    test_boundary_load();
    test_div_change();
    test_bad_load();
    test_en_stop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_n.md
# clk_div_n

Programmable integer clock divider: the successor to the fixed divide-by-3 block, generalised to any runtime divisor from 2 to 2^WIDTH-1. The output runs at exactly 50% duty for even divisors and, when the odd-duty feature is compiled in, for odd divisors too. Divisor changes are glitch-free, and run/stop takes effect only at period boundaries. It sits in the clock-generation area and feeds slow peripheral clocks and strobes.

## Interface
- WIDTH, 8: divisor width in bits.
- DEFAULT_DIV, 3: divisor loaded at reset; must be in 2..2^WIDTH-1.
- clk_in  input  1  source clock; all logic runs on its edges (posedge counter, one negedge flop).
- reset  input  1  asynchronous, active-low reset.
- en  input  1  run enable; sampled only at period boundaries.
- div_in  input  WIDTH  new divisor value.
- div_load  input  1  one-cycle request to load div_in.
- clk_out  output  1  divided clock.
- tick  output  1  one clk_in-cycle pulse at the start of each output period.
- cur_div  output  WIDTH  divisor currently in use.
- div_pend  output  1  a loaded divisor is waiting for the next boundary.
- div_err  output  1  one-cycle pulse: rejected load (div_in < 2).

## Operation
- Counter cnt runs 0..N-1 on posedge, where N = cur_div. A boundary is the posedge where cnt == N-1.
- pos_hi is a posedge register, set to (next cnt < N>>1). High phase lasts floor(N/2) cycles, starting at cnt = 0.
- Even N: clk_out = pos_hi, giving high N/2 and low N/2 cycles.
- Odd N: see Configuration.
- At a boundary:
  - If en = 1: cnt <= 0, pos_hi <= 1, tick <= 1. If div_pend is set, cur_div takes the pending value, div_pend clears, and the new N governs this period.
  - If en = 0: cnt holds at N-1, pos_hi = 0, clk_out stays low (stopped). While stopped, every posedge is a boundary.
- An en change mid-period is ignored until the next boundary, so there are no runt pulses.
- Divisor load:
  - div_load with div_in >= 2: value goes to the pending register and div_pend = 1 next cycle.
  - A second valid load while pending overwrites the pending value.
  - div_load with div_in < 2: div_err = 1 for one cycle; pending register and div_pend are unchanged.
- Simultaneous events:
  - div_load on a boundary cycle: the boundary uses the previously pending value, if any. The new value becomes pending and applies at the following boundary.
  - Loading the same value as cur_div still sets div_pend and completes normally.
- Arithmetic: cnt is WIDTH bits and never exceeds cur_div-1. The half value is cur_div >> 1 (no rounding).

## Timing
- Reset asserted: cnt = DEFAULT_DIV-1, pos_hi = 0, neg flop = 0, clk_out = 0, tick = 0, cur_div = DEFAULT_DIV, div_pend = 0, div_err = 0, pending register = DEFAULT_DIV.
- Reset is a valid stop state. Reset mid-period forces clk_out low immediately (asynchronous) and discards any pending load.
- First posedge after reset deassertion with en = 1: clk_out rises and tick = 1 in that cycle.
- tick, div_pend, div_err and cur_div are posedge registers (1-cycle latency from cause).
- The clk_out rising edge is aligned to the posedge; the odd-N falling edge is aligned to a negedge.
- Output period is exactly N clk_in cycles while en = 1.

## Configuration
- CLK_DIV_ODD_DUTY_EN, defined:
  - A negedge flop captures pos_hi, and for odd N, clk_out = pos_hi OR neg_q.
  - Result: high N/2 cycles (e.g. 1.5 of 3), low N/2, i.e. exactly 50% duty.
  - Even N still uses pos_hi only.
- CLK_DIV_ODD_DUTY_EN, undefined:
  - No negedge logic; clk_out = pos_hi for all N.
  - Odd N gives high floor(N/2), low ceil(N/2) (e.g. N = 3: high 1, low 2).

## Test plan
- Reset, en = 1, default N = 3, macro defined: clk_out high 1.5 cycles, low 1.5 cycles, period 3; tick every 3rd posedge.
- N = 3, macro undefined: clk_out high 1 cycle, low 2 cycles; first rise at the first posedge after reset release.
- div_load with div_in = 8 at cnt = 0 under N = 5: div_pend = 1 until the boundary 4 cycles later, then cur_div = 8 and clk_out high 4 / low 4 with no short pulse.
- div_load with div_in = 1, then with div_in = 0: div_err pulses once per load; cur_div and div_pend unchanged.
- Drop en mid-period under N = 6: the current period completes, then clk_out stays low and tick stays 0. Raise en: clk_out rises at the next posedge with tick = 1.
- Assert reset during a clk_out high phase with a pending load: clk_out = 0 immediately; after release cur_div = DEFAULT_DIV and div_pend = 0.
